// File: rtl/add32_serial8.sv
// Purpose: byte-serial wide adder; one 8-bit ripple add per clock, carry chained through a register.
// Latency: START accepted at edge k -> DONE/SUM/COUT/OVF valid in the cycle after edge k+NBYTES.
// Backpressure: none; START is ignored while BUSY=1 and accepted again in the DONE cycle.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               request, sampled only while o_busy=0
//   i_a, i_b, i_cin       operands and carry-in, captured on the accepting edge
//   o_busy                operation in progress
//   o_done                one-cycle result-valid pulse
//   o_sum, o_cout, o_ovf  result, carry out of MSB byte, signed overflow (held until next DONE)

// 4-bit ripple stage.
module adder4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

// 8-bit ripple adder: low nibble carry feeds the high nibble.
module adder8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic w_c4;

    adder4 u_lo (
        .i_a    (i_a[3:0]),
        .i_b    (i_b[3:0]),
        .i_cin  (i_cin),
        .o_sum  (o_sum[3:0]),
        .o_cout (w_c4)
    );

    adder4 u_hi (
        .i_a    (i_a[7:4]),
        .i_b    (i_b[7:4]),
        .i_cin  (w_c4),
        .o_sum  (o_sum[7:4]),
        .o_cout (o_cout)
    );
endmodule

module add32_serial8 #(
    parameter int NBYTES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [8*NBYTES-1:0] i_a,
    input  logic [8*NBYTES-1:0] i_b,
    input  logic                i_cin,
    output logic                o_busy,
    output logic                o_done,
    output logic [8*NBYTES-1:0] o_sum,
    output logic                o_cout,
    output logic                o_ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_carry;
    logic [W-1:0]  r_psum;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_done;
    logic          r_busy;

    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic [7:0]    w_add_sum;
    logic          w_add_cout;
    logic [W-1:0]  w_psum_next;

    // Byte mux: only one 8-bit slice feeds the adder per cycle.
    assign w_a_byte = r_a[r_idx*8 +: 8];
    assign w_b_byte = r_b[r_idx*8 +: 8];

    adder8 u_adder8 (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Partial sum with this cycle's byte merged in, so the last edge can
    // publish the complete word including the byte being written.
    always_comb begin
        w_psum_next = r_psum;
        w_psum_next[r_idx*8 +: 8] = w_add_sum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_psum  <= w_psum_next;
                    r_carry <= w_add_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_psum_next;
                        r_cout  <= w_add_cout;
                        // Signed overflow: like-signed operands, result sign differs.
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_psum_next[W-1] != r_a[W-1]);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_add32_serial8.sv
// Purpose: self-checking bench for add32_serial8 (NBYTES=4) using directed vectors and a few random ops.
// Latency: checks DONE exactly 4 cycles after the accepting edge, back-to-back with no gap.
// Backpressure: exercises START held during BUSY and START re-asserted in the DONE cycle.
module tb_add32_serial8;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    add32_serial8 #(.NBYTES(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits just after a clock edge; drives a request and returns #1 after the accepting edge.
    task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'(1'b1));
        chk("done_low_after_accept", 64'(done), 64'(1'b0));
    endtask

    // Called #1 after the accepting edge; returns #1 after the edge that raised DONE.
    task automatic wait_done(input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            chk("done_timeout", 64'(done), 64'(1'b1));
        end else begin
            chk("latency", 64'(cyc), 64'd4);
            chk("busy_cycles", 64'(busy_cnt), 64'd4);
            chk("busy_at_done", 64'(busy), 64'(1'b0));
            chk("sum", 64'(sum), 64'(e_sum));
            chk("cout", 64'(cout), 64'(e_cout));
            chk("ovf", 64'(ovf), 64'(e_ovf));
        end
    endtask

    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
        launch(va, vb, vc);
        wait_done(e_sum, e_cout, e_ovf);
    endtask

    initial begin
        int          done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] full;
        logic        r_ovf_exp;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'(1'b0));
        chk("rst_ovf", 64'(ovf), 64'(1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results.
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Reset mid-RUN after the second byte edge: outputs clear, no DONE follows.
        launch(32'h0102_0304, 32'h1020_3040, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_done", 64'(done), 64'(1'b0));
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'(1'b0));
        chk("midrst_ovf", 64'(ovf), 64'(1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, 1'b0);

        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // START held through BUSY with changed operands: first result unaffected,
        // the still-high START in the DONE cycle launches the second operation.
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        wait_done(32'h2345_6789, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_busy_restart", 64'(busy), 64'(1'b1));
        chk("hold_done_onecycle", 64'(done), 64'(1'b0));
        wait_done(32'h0000_0000, 1'b1, 1'b0);

        // Random back-to-back operations, each launched in the previous DONE cycle.
        for (int i = 0; i < 8; i++) begin
            ra        = $urandom;
            rb        = $urandom;
            rc        = 1'($urandom_range(0, 1));
            full      = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            r_ovf_exp = (ra[31] == rb[31]) && (full[31] != ra[31]);
            do_op(ra, rb, rc, full[31:0], full[32], r_ovf_exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
